wb_uart_tx: RTL

- Observer at the register write-back end of the processing unit.
- Consumes the `we`/`rwd` write-back stream, which the unit drives as outputs, and buffers each written word in a FIFO.
- Serialises the buffered words onto a UART line (8N1, LSB byte first) for an external logger.
- Pure receiver of write-back traffic: no back-pressure to the processing unit; words that arrive while the FIFO is full are dropped and flagged.

---
 rtl/wb_uart_tx.sv | 90 +++++++++
 1 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: write-back FIFO serialised 8N1 LSB byte first; define WB_TX_SYNC_EN to prefix each word with a 0xA5 sync byte
module wb_uart_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [DATA_W-1:0]        rwd,
  output logic                     txd,
  output logic                     busy,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   count
);
`ifdef WB_TX_SYNC_EN
  localparam int NB = DATA_W/8 + 1;
`else
  localparam int NB = DATA_W/8;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NB+1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic [NB*8-1:0] r_sh, w_load;
  logic [CW-1:0] r_baud;
  logic [2:0] r_bit, w_bit;
  logic [BW-1:0] r_byte;
  logic r_txd, r_ovf, w_tick, w_pop, w_push, w_txd;
  always_comb begin
    w_tick = r_baud == CW'(CLKS_PER_BIT-1);
    w_pop = r_state == IDLE && r_count != '0;
    w_push = we && (r_count != (AW+1)'(DEPTH) || w_pop);
    w_next = r_state == IDLE ? (w_pop ? START : IDLE) :
             !w_tick ? r_state :
             r_state == START ? DATA :
             r_state == DATA ? (r_bit == 3'd7 ? STOP : DATA) :
             r_byte == BW'(NB-1) ? IDLE : START;
    w_bit = (r_state == DATA && w_tick) ? r_bit + 3'd1 : r_bit;
    w_txd = w_next == START ? 1'b0 : w_next == DATA ? r_sh[w_bit] : 1'b1;
`ifdef WB_TX_SYNC_EN
    w_load = {r_mem[r_rp], 8'hA5};
`else
    w_load = r_mem[r_rp];
`endif
  end
  always_ff @(posedge clk)
    if (!rst && w_push) r_mem[r_wp] <= rwd;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_baud <= '0;
      r_bit <= '0;
      r_byte <= '0;
      r_sh <= '0;
      r_txd <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      r_baud <= (w_next != r_state || w_tick) ? '0 : r_baud + CW'(1);
      r_txd <= w_txd;
      r_ovf <= r_ovf | (we & ~w_push);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
        r_sh <= w_load;
        r_bit <= '0;
        r_byte <= '0;
      end else begin
        r_bit <= w_bit;
        if (r_state == STOP && w_tick) begin
          r_sh <= r_sh >> 8;
          r_byte <= r_byte + BW'(1);
        end
      end
    end
  end
  assign txd = r_txd;
  assign busy = r_state != IDLE;
  assign ovf = r_ovf;
  assign count = r_count;
endmodule
